// File: rtl/vote_tally_reader_if.sv
// rtl/vote_tally_reader_if.sv - vote BRAM read port and majority-class result stream
// VOTE_TALLY_CONF_EN adds cls_votes (winning class tally) to the result stream.
interface vote_tally_reader_if #(
  parameter int DEPTH_BIT = 10,
  parameter int N_CLASSES = 8,
  parameter int TREE_BIT  = 8
);
  localparam int CW = $clog2(N_CLASSES);

  logic                 rd_en;
  logic [DEPTH_BIT-1:0] rd_addr;
  logic [31:0]          rd_data;
  logic                 cls_vld;
  logic                 cls_rdy;
  logic [CW-1:0]        cls_val;
  logic [DEPTH_BIT-1:0] cls_sample;
`ifdef VOTE_TALLY_CONF_EN
  logic [TREE_BIT-1:0]  cls_votes;
`endif

  modport master (
    output rd_en, rd_addr, cls_vld, cls_val, cls_sample,
`ifdef VOTE_TALLY_CONF_EN
    output cls_votes,
`endif
    input  rd_data, cls_rdy
  );

  modport slave (
    input  rd_en, rd_addr, cls_vld, cls_val, cls_sample,
`ifdef VOTE_TALLY_CONF_EN
    input  cls_votes,
`endif
    output rd_data, cls_rdy
  );
endinterface

// File: rtl/vote_tally_reader.sv
// rtl/vote_tally_reader.sv - walks vote BRAM in samples of n_trees entries and streams the majority class
// VOTE_TALLY_CONF_EN adds cls_votes, the winning class tally held with cls_vld.
module vote_tally_reader #(
  parameter int RES_WIDTH = 16,
  parameter int DEPTH_BIT = 10,
  parameter int N_CLASSES = 8,
  parameter int TREE_BIT  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DEPTH_BIT-1:0] n_results,
  input  logic [TREE_BIT-1:0]  n_trees,
  output logic                 busy,
  output logic                 done,
  output logic [DEPTH_BIT-1:0] err_cnt,
  vote_tally_reader_if.master  bus
);
  localparam int CW = $clog2(N_CLASSES);
  localparam int SW = ((DEPTH_BIT > TREE_BIT) ? DEPTH_BIT : TREE_BIT) + 2;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, EMIT, FINISH} state_t;
  state_t state;

  logic [DEPTH_BIT-1:0] nres_q;
  logic [TREE_BIT-1:0]  ntrees_q;
  logic [TREE_BIT-1:0]  rd_cnt;
  logic                 rd_en_q;
  logic [DEPTH_BIT-1:0] rd_addr_q;
  logic                 vld_d;
  logic                 cls_vld_q;
  logic [CW-1:0]        cls_val_q;
  logic [DEPTH_BIT-1:0] cls_sample_q;
  logic [TREE_BIT-1:0]  tally     [N_CLASSES];
  logic [TREE_BIT-1:0]  tally_nxt [N_CLASSES];
  logic [CW-1:0]        best_idx;
  logic [TREE_BIT-1:0]  best_cnt;

  logic [RES_WIDTH-1:0] res;
  logic                 res_ok;
  logic                 unused_rd_hi;
  logic [SW-1:0]        next_end;

  assign res          = bus.rd_data[RES_WIDTH-1:0];
  assign res_ok       = ({{(32-RES_WIDTH){1'b0}}, res} < 32'(N_CLASSES));
  assign unused_rd_hi = ^bus.rd_data[31:RES_WIDTH];
  // One past the last address the next sample would need.
  assign next_end     = SW'(rd_addr_q) + SW'(1) + SW'(ntrees_q);

  // Tally including the word returning this cycle, so DRAIN can emit without a bubble.
  always_comb begin
    for (int c = 0; c < N_CLASSES; c++) begin
      tally_nxt[c] = tally[c];
      if (vld_d && res_ok && (res[CW-1:0] == CW'(c)) && (tally[c] != '1))
        tally_nxt[c] = tally[c] + 1'b1;
    end
  end

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_cnt = tally_nxt[0];
    for (int c = 1; c < N_CLASSES; c++) begin
      if (tally_nxt[c] > best_cnt) begin
        best_idx = CW'(c);
        best_cnt = tally_nxt[c];
      end
    end
  end

`ifdef VOTE_TALLY_CONF_EN
  logic [TREE_BIT-1:0] cls_votes_q;
  assign bus.cls_votes = cls_votes_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_cnt      <= '0;
      nres_q       <= '0;
      ntrees_q     <= '0;
      rd_cnt       <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      vld_d        <= 1'b0;
      cls_vld_q    <= 1'b0;
      cls_val_q    <= '0;
      cls_sample_q <= '0;
      for (int c = 0; c < N_CLASSES; c++) tally[c] <= '0;
`ifdef VOTE_TALLY_CONF_EN
      cls_votes_q  <= '0;
`endif
    end else begin
      vld_d <= rd_en_q;
      done  <= 1'b0;
      for (int c = 0; c < N_CLASSES; c++) tally[c] <= tally_nxt[c];
      if (vld_d && !res_ok && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            nres_q       <= n_results;
            ntrees_q     <= n_trees;
            err_cnt      <= '0;
            cls_sample_q <= '0;
            rd_cnt       <= '0;
            rd_addr_q    <= '0;
            for (int c = 0; c < N_CLASSES; c++) tally[c] <= '0;
            if ((n_trees == '0) || (SW'(n_results) < SW'(n_trees))) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              busy    <= 1'b1;
              rd_en_q <= 1'b1;
              state   <= READ;
            end
          end
        end
        READ: begin
          if (rd_cnt == ntrees_q - 1'b1) begin
            rd_en_q <= 1'b0;
            state   <= DRAIN;
          end else begin
            rd_cnt    <= rd_cnt + 1'b1;
            rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        DRAIN: begin
          cls_vld_q   <= 1'b1;
          cls_val_q   <= best_idx;
`ifdef VOTE_TALLY_CONF_EN
          cls_votes_q <= best_cnt;
`endif
          state       <= EMIT;
        end
        EMIT: begin
          if (bus.cls_rdy) begin
            cls_vld_q    <= 1'b0;
            cls_sample_q <= cls_sample_q + 1'b1;
            for (int c = 0; c < N_CLASSES; c++) tally[c] <= '0;
            if (next_end > SW'(nres_q)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              rd_cnt    <= '0;
              rd_addr_q <= rd_addr_q + 1'b1;
              rd_en_q   <= 1'b1;
              state     <= READ;
            end
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.cls_vld    = cls_vld_q;
  assign bus.cls_val    = cls_val_q;
  assign bus.cls_sample = cls_sample_q;
endmodule

// File: tb/tb_vote_tally_reader.sv
// tb/tb_vote_tally_reader.sv - directed bench for vote_tally_reader with a 1-cycle BRAM model
// VOTE_TALLY_CONF_EN enables the cls_votes checks.
module tb_vote_tally_reader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] n_results = '0;
  logic [7:0] n_trees = '0;
  logic       busy, done;
  logic [9:0] err_cnt;

  vote_tally_reader_if #(.DEPTH_BIT(10), .N_CLASSES(8), .TREE_BIT(8)) bus ();

  vote_tally_reader #(.RES_WIDTH(16), .DEPTH_BIT(10), .N_CLASSES(8), .TREE_BIT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .n_results (n_results),
    .n_trees   (n_trees),
    .busy      (busy),
    .done      (done),
    .err_cnt   (err_cnt),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  int checks = 0, failures = 0;
  int cyc = 0, rd_count = 0, vld_cycles = 0;
  int addr_hits [1024];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.cls_vld) vld_cycles <= vld_cycles + 1;
    if (bus.rd_en) begin
      rd_count <= rd_count + 1;
      addr_hits[bus.rd_addr] <= addr_hits[bus.rd_addr] + 1;
      bus.rd_data <= mem[bus.rd_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int n, input int v0, v1, v2, v3, v4, v5, v6, v7, v8, v9);
    int vals [10];
    vals = '{v0, v1, v2, v3, v4, v5, v6, v7, v8, v9};
    for (int i = 0; i < n; i++) mem[i] = vals[i];
  endtask

  task automatic pulse_start(input int nr, input int nt);
    @(negedge clk);
    n_results = 10'(nr);
    n_trees   = 8'(nt);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_vld(input string tag);
    int k = 0;
    while (!bus.cls_vld && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_vld"}, 32'(bus.cls_vld), 1);
  endtask

  task automatic take_result(input string tag, input int exp_val, input int exp_sample, output int at_cyc);
    wait_vld(tag);
    at_cyc = cyc;
    chk({tag, "_val"}, 32'(bus.cls_val), exp_val);
    chk({tag, "_sample"}, 32'(bus.cls_sample), exp_sample);
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, 32'(done), 1);
    @(negedge clk);
  endtask

  initial begin
    int c0, c1, base_rd, base_vld, base_h6, bad;
    logic [2:0] held_val;
    logic [9:0] held_sample;
    bus.cls_rdy = 1'b0;
    bus.rd_data = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_en", 32'(bus.rd_en), 0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 0);
    chk("rst_cls_vld", 32'(bus.cls_vld), 0);
    chk("rst_cls_val", 32'(bus.cls_val), 0);
    chk("rst_cls_sample", 32'(bus.cls_sample), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    rst_n = 1'b1;

    // Two full samples with ready held high
    load(10, 1, 1, 2, 1, 3, 4, 4, 4, 0, 0);
    bus.cls_rdy = 1'b1;
    base_rd = rd_count;
    pulse_start(10, 5);
    chk("t1_busy", 32'(busy), 1);
    wait_vld("t1_s0");
`ifdef VOTE_TALLY_CONF_EN
    chk("t1_votes", 32'(bus.cls_votes), 3);
`endif
    take_result("t1_s0", 1, 0, c0);
    take_result("t1_s1", 4, 1, c1);
    chk("t1_done_pulse", 32'(done), 1);
    chk("t1_period", 32'(c1 - c0), 7);
    @(negedge clk);
    chk("t1_done_low", 32'(done), 0);
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_reads", 32'(rd_count - base_rd), 10);
    chk("t1_err", 32'(err_cnt), 0);

    // Tie resolves to the lower class index
    load(4, 3, 2, 2, 3, 0, 0, 0, 0, 0, 0);
    pulse_start(4, 4);
    wait_vld("t2");
`ifdef VOTE_TALLY_CONF_EN
    chk("t2_votes", 32'(bus.cls_votes), 2);
`endif
    take_result("t2", 2, 0, c0);
    wait_done("t2");
    chk("t2_err", 32'(err_cnt), 0);

    // Out-of-range results counted, not tallied
    load(3, 9, 5, 12, 0, 0, 0, 0, 0, 0, 0);
    pulse_start(3, 3);
    take_result("t3", 5, 0, c0);
    wait_done("t3");
    chk("t3_err", 32'(err_cnt), 2);

    // Backpressure holds the result and stalls reads
    load(5, 1, 1, 2, 1, 3, 0, 0, 0, 0, 0);
    bus.cls_rdy = 1'b0;
    pulse_start(5, 5);
    wait_vld("t4");
    held_val = bus.cls_val;
    held_sample = bus.cls_sample;
    chk("t4_val", 32'(held_val), 1);
    base_rd = rd_count;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.cls_vld || bus.cls_val !== held_val || bus.cls_sample !== held_sample || bus.rd_en) bad++;
    end
    chk("t4_stall_bad_cycles", 32'(bad), 0);
    chk("t4_stall_reads", 32'(rd_count - base_rd), 0);
    bus.cls_rdy = 1'b1;
    @(negedge clk);
    wait_done("t4");

    // Leftover entry never read
    load(7, 0, 0, 1, 2, 2, 2, 7, 0, 0, 0);
    base_rd = rd_count;
    base_h6 = addr_hits[6];
    pulse_start(7, 3);
    take_result("t5_s0", 0, 0, c0);
    take_result("t5_s1", 2, 1, c1);
    chk("t5_done_pulse", 32'(done), 1);
    chk("t5_reads", 32'(rd_count - base_rd), 6);
    chk("t5_addr6_hits", 32'(addr_hits[6] - base_h6), 0);
    @(negedge clk);

    // n_trees == 0 aborts with only a done pulse
    base_rd = rd_count;
    base_vld = vld_cycles;
    pulse_start(10, 0);
    chk("t6_done", 32'(done), 1);
    chk("t6_busy", 32'(busy), 0);
    @(negedge clk);
    chk("t6_done_low", 32'(done), 0);
    chk("t6_reads", 32'(rd_count - base_rd), 0);
    chk("t6_no_vld", 32'(vld_cycles - base_vld), 0);

    // Asynchronous reset mid-READ, then a clean pass
    load(10, 1, 1, 2, 1, 3, 4, 4, 4, 0, 0);
    pulse_start(10, 5);
    @(negedge clk);
    chk("t7_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_busy", 32'(busy), 0);
    chk("t7_rst_rd_en", 32'(bus.rd_en), 0);
    chk("t7_rst_rd_addr", 32'(bus.rd_addr), 0);
    chk("t7_rst_done", 32'(done), 0);
    chk("t7_rst_cls_vld", 32'(bus.cls_vld), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(10, 5);
    take_result("t7_s0", 1, 0, c0);
    take_result("t7_s1", 4, 1, c1);
    chk("t7_done_pulse", 32'(done), 1);
    chk("t7_err", 32'(err_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
